// File: rtl/result_tx_formatter_pkg.sv
// Shared ASCII codes and sequencer state encoding for the UART result path.
// The command-character codes are the ones the upstream parser matches on.
package result_tx_formatter_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_MINUS = 8'd45;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;

  localparam logic [7:0] ASCII_CMD_F = 8'h66;
  localparam logic [7:0] ASCII_CMD_S = 8'h73;
  localparam logic [7:0] ASCII_CMD_O = 8'h6F;
  localparam logic [7:0] ASCII_CMD_D = 8'h64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_FIN
  } tx_state_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
    return ASCII_ZERO + {4'd0, digit};
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle for W cycles,
// then a one-cycle done_tick with the NDIG BCD digits valid on bcd.
module bin2bcd
  import result_tx_formatter_pkg::*;
#(
  parameter int W    = 8,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      bin,
  output logic [4*NDIG-1:0] bcd,
  output logic              done_tick
);

  localparam int BW = 4 * NDIG;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  logic [SW-1:0] sr_reg;
  logic [SW-1:0] adj_sr;
  logic [SW-1:0] sr_next;
  logic [BW-1:0] adj_bcd;
  logic [CW-1:0] count_reg;
  logic          done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_adj
      assign adj_bcd[4*gi +: 4] = (sr_reg[W + 4*gi +: 4] >= 4'd5)
                                  ? sr_reg[W + 4*gi +: 4] + 4'd3
                                  : sr_reg[W + 4*gi +: 4];
    end
  endgenerate

  // Rotate rather than shift: the BCD overflow bit is always zero and lands
  // in the already-consumed binary end, so every bit of the register is live.
  assign adj_sr  = {adj_bcd, sr_reg[W-1:0]};
  assign sr_next = {adj_sr[SW-2:0], adj_sr[SW-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_reg    <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        sr_reg    <= {{BW{1'b0}}, bin};
        count_reg <= CW'(W);
      end else if (count_reg != '0) begin
        sr_reg    <= sr_next;
        count_reg <= count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign bcd       = sr_reg[SW-1 -: BW];
  assign done_tick = done_reg;

endmodule

// File: rtl/result_tx_formatter.sv
// Turns one ALU result into ASCII decimal text ('-', digits, CR LF) and feeds
// it byte by byte to a UART transmitter over the tx_start/tx_done_tick handshake.
module result_tx_formatter
  import result_tx_formatter_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int W         = 8,
  parameter int NDIG      = 3,
  parameter int SIGNED    = 1,
  parameter int SEND_CRLF = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    result,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [DBIT-1:0] d_in,
  output logic            busy,
  output logic            done_tick
);

  localparam int BW = 4 * NDIG;
  localparam int PW = $clog2(NDIG + 4);

  // Frame positions: 0 = '-', 1..NDIG = digits (most significant first),
  // then CR, LF, and an end marker.
  localparam logic [PW-1:0] POS_MINUS = '0;
  localparam logic [PW-1:0] POS_UNITS = PW'(NDIG);
  localparam logic [PW-1:0] POS_CR    = PW'(NDIG + 1);
  localparam logic [PW-1:0] POS_LF    = PW'(NDIG + 2);
  localparam logic [PW-1:0] POS_END   = PW'(NDIG + 3);

  tx_state_t       state_reg, state_next;
  logic [PW-1:0]   idx_reg, idx_next;
  logic            neg_reg, neg_next;
  logic [BW-1:0]   digits_reg, digits_next;
  logic [DBIT-1:0] d_in_reg, d_in_next;
  logic [BW-1:0]   bcd;
  logic [W-1:0]    mag;
  logic            is_neg;
  logic            conv_start;
  logic            conv_done;

  // Units digit is always sent; otherwise start at the highest nonzero digit.
  function automatic logic [PW-1:0] first_pos(input logic [BW-1:0] dg);
    logic [PW-1:0] f;
    f = POS_UNITS;
    for (int i = 1; i < NDIG; i++) begin
      if (dg[4*i +: 4] != 4'd0) begin
        f = PW'(NDIG - i);
      end
    end
    return f;
  endfunction

  function automatic logic [PW-1:0] next_pos(input logic [PW-1:0] p,
                                             input logic [BW-1:0] dg);
    logic [PW-1:0] n;
    if (p == POS_MINUS) begin
      n = first_pos(dg);
    end else if (p < POS_UNITS) begin
      n = p + PW'(1);
    end else if (p == POS_UNITS) begin
      n = (SEND_CRLF != 0) ? POS_CR : POS_END;
    end else if (p == POS_CR) begin
      n = POS_LF;
    end else begin
      n = POS_END;
    end
    return n;
  endfunction

  function automatic logic [7:0] char_at(input logic [PW-1:0] p,
                                         input logic [BW-1:0] dg);
    logic [7:0] c;
    c = 8'd0;
    if (p == POS_MINUS) begin
      c = ASCII_MINUS;
    end else if (p == POS_CR) begin
      c = ASCII_CR;
    end else if (p == POS_LF) begin
      c = ASCII_LF;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (p == PW'(NDIG - i)) begin
          c = ascii_digit(dg[4*i +: 4]);
        end
      end
    end
    return c;
  endfunction

  // Two's-complement negate in W bits is exact here: the most negative value
  // maps onto 2**(W-1), which still fits as an unsigned magnitude.
  assign is_neg = (SIGNED != 0) && result[W-1];
  assign mag    = is_neg ? (W'(0) - result) : result;

  bin2bcd #(
    .W   (W),
    .NDIG(NDIG)
  ) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .start    (conv_start),
    .bin      (mag),
    .bcd      (bcd),
    .done_tick(conv_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      neg_reg    <= 1'b0;
      digits_reg <= '0;
      d_in_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      neg_reg    <= neg_next;
      digits_reg <= digits_next;
      d_in_reg   <= d_in_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    neg_next    = neg_reg;
    digits_next = digits_reg;
    d_in_next   = d_in_reg;
    conv_start  = 1'b0;
    tx_start    = 1'b0;
    busy        = 1'b1;
    done_tick   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          conv_start = 1'b1;
          neg_next   = is_neg;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          digits_next = bcd;
          idx_next    = neg_reg ? POS_MINUS : first_pos(bcd);
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        d_in_next  = DBIT'(char_at(idx_reg, digits_reg));
        state_next = ST_SEND;
      end
      ST_SEND: begin
        tx_start   = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          if (next_pos(idx_reg, digits_reg) == POS_END) begin
            state_next = ST_FIN;
          end else begin
            idx_next   = next_pos(idx_reg, digits_reg);
            state_next = ST_LOAD;
          end
        end
      end
      ST_FIN: begin
        done_tick  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign d_in = d_in_reg;

endmodule

// File: tb/tb_result_tx_formatter.sv
// Directed bench: three formatter variants (unsigned+CRLF, signed+CRLF,
// unsigned without CRLF) share stimulus; each has its own UART tx model.
module tb_result_tx_formatter;

  localparam int TW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [TW-1:0] result;

  logic       tx_done_v [NI];
  logic       tx_start_v[NI];
  logic [7:0] d_in_v    [NI];
  logic       busy_v    [NI];
  logic       done_v    [NI];
  int         uart_cnt  [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      result_tx_formatter #(
        .DBIT     (8),
        .W        (TW),
        .NDIG     (3),
        .SIGNED   ((gi == 1) ? 1 : 0),
        .SEND_CRLF((gi == 2) ? 0 : 1)
      ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .result      (result),
        .tx_done_tick(tx_done_v[gi]),
        .tx_start    (tx_start_v[gi]),
        .d_in        (d_in_v[gi]),
        .busy        (busy_v[gi]),
        .done_tick   (done_v[gi])
      );
    end
  endgenerate

  // UART tx model: byte finishes 10 cycles after tx_start; not reset by the DUT reset.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      tx_done_v[i] <= 1'b0;
      if (uart_cnt[i] != 0) begin
        uart_cnt[i] <= uart_cnt[i] - 1;
        if (uart_cnt[i] == 1) tx_done_v[i] <= 1'b1;
      end else if (tx_start_v[i] === 1'b1) begin
        uart_cnt[i] <= 10;
      end
    end
  end

  int         checks = 0;
  int         passes = 0;
  logic [7:0] cap      [NI][8];
  int         cap_n    [NI];
  int         done_cnt [NI];
  int         lat      [NI];
  bit         armed    [NI];
  bit         in_flight[NI];
  bit         prev_tx  [NI];
  logic [7:0] held     [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock: advance to the falling edge and run the protocol monitor.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        in_flight[i] = 1'b0;
        armed[i]     = 1'b0;
        prev_tx[i]   = 1'b0;
      end else begin
        if (armed[i]) lat[i]++;
        if (tx_start_v[i] === 1'b1) begin
          chk($sformatf("inst%0d tx_start_back_to_back", i), {31'd0, prev_tx[i]}, 32'd0);
          if (armed[i]) begin
            chk($sformatf("inst%0d start_to_tx_start_latency", i), lat[i], TW + 3);
            armed[i] = 1'b0;
          end
          if (cap_n[i] < 8) begin
            cap[i][cap_n[i]] = d_in_v[i];
            cap_n[i]++;
          end
          held[i]      = d_in_v[i];
          in_flight[i] = 1'b1;
        end else if (in_flight[i]) begin
          chk($sformatf("inst%0d d_in_stable", i), {24'd0, d_in_v[i]}, {24'd0, held[i]});
        end
        if (tx_done_v[i] === 1'b1) in_flight[i] = 1'b0;
        if (done_v[i] === 1'b1) done_cnt[i]++;
        prev_tx[i] = (tx_start_v[i] === 1'b1);
      end
    end
  endtask

  task automatic clear_caps();
    for (int i = 0; i < NI; i++) begin
      cap_n[i]    = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic pulse_start(input logic [TW-1:0] r);
    result = r;
    start  = 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (busy_v[i] === 1'b0) begin
        armed[i] = 1'b1;
        lat[i]   = 0;
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      ok = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (busy_v[i] !== 1'b0 || done_cnt[i] < 1) ok = 1'b0;
      end
      if (ok) break;
      tick();
    end
    chk({tag, " frame_completed_in_time"}, {31'd0, ok}, 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag, input string e0, input string e1, input string e2);
    string e[NI];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s inst%0d byte_count", tag, i), cap_n[i], e[i].len());
      for (int j = 0; j < e[i].len() && j < cap_n[i]; j++) begin
        chk($sformatf("%s inst%0d byte%0d", tag, i, j), {24'd0, cap[i][j]}, {24'd0, e[i][j]});
      end
      chk($sformatf("%s inst%0d done_tick_count", tag, i), done_cnt[i], 1);
      chk($sformatf("%s inst%0d busy_after", tag, i), {31'd0, busy_v[i]}, 32'd0);
      $display("frame %s inst%0d: %0d bytes, %0d done_tick(s)", tag, i, cap_n[i], done_cnt[i]);
    end
  endtask

  task automatic run_frame(input logic [TW-1:0] r, input string tag,
                           input string e0, input string e1, input string e2);
    clear_caps();
    pulse_start(r);
    wait_idle(tag);
    check_frame(tag, e0, e1, e2);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    result = '0;
    for (int i = 0; i < NI; i++) begin
      uart_cnt[i] = 0;
      cap_n[i]    = 0;
      done_cnt[i] = 0;
      lat[i]      = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset inst%0d tx_start", i), {31'd0, tx_start_v[i]}, 32'd0);
      chk($sformatf("reset inst%0d busy", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("reset inst%0d d_in", i), {24'd0, d_in_v[i]}, 32'd0);
      chk($sformatf("reset inst%0d done_tick", i), {31'd0, done_v[i]}, 32'd0);
    end
    reset = 1'b0;
    tick();

    // Values chosen for max unsigned, most negative, zero, single digit and inner zeros.
    run_frame(8'd255, "r255", "255\r\n", "-1\r\n", "255");
    run_frame(8'h80,  "r128", "128\r\n", "-128\r\n", "128");
    run_frame(8'd0,   "r0",   "0\r\n", "0\r\n", "0");
    run_frame(8'd7,   "r7",   "7\r\n", "7\r\n", "7");
    run_frame(8'd100, "r100", "100\r\n", "100\r\n", "100");
    run_frame(8'h9C,  "r156", "156\r\n", "-100\r\n", "156");

    // Second start arrives while the first byte is in WAIT; it must be dropped.
    clear_caps();
    pulse_start(8'd7);
    repeat (12) tick();
    pulse_start(8'd255);
    wait_idle("ignored_start");
    check_frame("ignored_start", "7\r\n", "7\r\n", "7");
    run_frame(8'd255, "after_ignore", "255\r\n", "-1\r\n", "255");

    // Reset during WAIT of the second byte aborts the frame for good.
    clear_caps();
    pulse_start(8'd255);
    for (int k = 0; k < 200 && cap_n[0] < 2; k++) tick();
    chk("abort reached_second_byte", cap_n[0], 2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("abort inst%0d tx_start", i), {31'd0, tx_start_v[i]}, 32'd0);
      chk($sformatf("abort inst%0d busy", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("abort inst%0d d_in", i), {24'd0, d_in_v[i]}, 32'd0);
    end
    reset = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("abort inst%0d busy_after_late_tick", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("abort inst%0d no_more_bytes", i), cap_n[i], 2);
      chk($sformatf("abort inst%0d no_done_tick", i), done_cnt[i], 0);
    end
    $display("abort: frame cut after 2 bytes, DUT idle");
    run_frame(8'd255, "after_abort", "255\r\n", "-1\r\n", "255");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
